// File: rtl/spi_sched_pkg.sv
// Shared constants for the SPI transmit scheduler: FSM encoding, AXI response codes, write strobe.
package spi_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [3:0] WSTRB_BYTE0 = 4'b0001;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(off);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one AXI-lite SPI byte sender among NUM_REQ requesters.
// Optional B-wait timeout enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_tx_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   done,
  output logic [1:0]           done_resp,
  output logic                 busy,
  output logic [31:0]          m_awaddr,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("spi_tx_scheduler: unsupported NUM_REQ or TIMEOUT_CYC");
  end

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [7:0]         grant_byte;
  logic               accept;
  logic               resp_fire;
  logic               timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Encode the one-hot grant and pick the granted requester's byte.
  always_comb begin
    grant_idx  = '0;
    grant_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = PTR_W'(i);
        grant_byte = req_data[8*i +: 8];
      end
    end
  end

  assign ptr_next  = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
  assign accept    = resetn && (state == S_IDLE) && (|req_valid);
  assign resp_fire = resetn && (state == S_RESP) && (m_bvalid || timeout_hit);
  assign req_ready = accept ? grant : '0;
  assign done      = resp_fire ? (NUM_REQ'(1) << gidx) : '0;
  assign m_wstrb   = WSTRB_BYTE0;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tcnt;

  // Counts RESP cycles; cleared on the W handshake that enters RESP.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcnt <= '0;
    end else if (state == S_DATA && m_wready) begin
      tcnt <= '0;
    end else if (state == S_RESP && !resp_fire) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (tcnt == CNT_W'(TIMEOUT_CYC));
  assign done_resp   = !resp_fire ? OKAY : (m_bvalid ? m_bresp : SLVERR);
`else
  assign timeout_hit = 1'b0;
  assign done_resp   = resp_fire ? m_bresp : OKAY;
`endif

  // Transfer FSM: accept, AW, W, B strictly in sequence with one byte in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      busy      <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            gidx      <= grant_idx;
            ptr       <= ptr_next;
            m_awaddr  <= ADDR_BASE + 32'({grant_idx, 2'b00});
            m_wdata   <= {24'b0, grant_byte};
            m_awvalid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_awready) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b1;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_wready) begin
            m_wvalid <= 1'b0;
            m_bready <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_fire) begin
            m_bready <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed self-checking bench for spi_tx_scheduler (NUM_REQ=4, TIMEOUT_CYC=16).
module tb_spi_tx_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic [1:0]  done_resp;
  logic        busy;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  int checks;
  int failures;

  logic [3:0]  rr_oh   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] rr_addr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
  logic [31:0] rr_data [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};

  always #5 clk = ~clk;

  spi_tx_scheduler #(
    .NUM_REQ     (4),
    .ADDR_BASE   (32'h0),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .done      (done),
    .done_resp (done_resp),
    .busy      (busy),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b1;
    m_bresp   = 2'b11;

    // Reset state, with requests and a stray bvalid present.
    step();
    req_valid = 4'b1111;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_done_resp", 32'(done_resp), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_awvalid", 32'(m_awvalid), 32'h0);
    chk("rst_awaddr", m_awaddr, 32'h0);
    chk("rst_wvalid", 32'(m_wvalid), 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    chk("rst_wstrb", 32'(m_wstrb), 32'h1);
    chk("rst_bready", 32'(m_bready), 32'h0);
    step();

    // Test 1: single transfer, zero-wait slave.
    do_reset();
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b1;
    m_bresp   = 2'b00;
    req_data  = 32'h0000_00A5;
    req_valid = 4'b0001;
    #2;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_c0_busy", 32'(busy), 32'h0);
    chk("t1_c0_done", 32'(done), 32'h0);
    step();
    req_valid = '0;
    #2;
    chk("t1_awvalid", 32'(m_awvalid), 32'h1);
    chk("t1_awaddr", m_awaddr, 32'h0);
    chk("t1_c1_wvalid", 32'(m_wvalid), 32'h0);
    chk("t1_c1_busy", 32'(busy), 32'h1);
    step();
    #2;
    chk("t1_wvalid", 32'(m_wvalid), 32'h1);
    chk("t1_wdata", m_wdata, 32'h0000_00A5);
    chk("t1_c2_awvalid", 32'(m_awvalid), 32'h0);
    step();
    #2;
    chk("t1_bready", 32'(m_bready), 32'h1);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_done_resp", 32'(done_resp), 32'h0);
    step();
    #2;
    chk("t1_c4_busy", 32'(busy), 32'h0);
    chk("t1_c4_done", 32'(done), 32'h0);

    // Test 2: all four requesting and held, round-robin order 0,1,2,3,0.
    do_reset();
    req_data  = 32'h4433_2211;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t2_grant", 32'(req_ready), 32'(rr_oh[k]));
      step();
      #2;
      chk("t2_awaddr", m_awaddr, rr_addr[k]);
      step();
      #2;
      chk("t2_wdata", m_wdata, rr_data[k]);
      step();
      #2;
      chk("t2_done", 32'(done), 32'(rr_oh[k]));
      step();
    end
    req_valid = '0;

    // Test 3: AW backpressure for 5 cycles; request and data change after accept.
    do_reset();
    m_awready = 1'b0;
    req_data  = 32'h4433_2211;
    req_valid = 4'b0100;
    #2;
    chk("t3_req_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    req_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t3_hold_awvalid", 32'(m_awvalid), 32'h1);
      chk("t3_hold_awaddr", m_awaddr, 32'h8);
      chk("t3_hold_wvalid", 32'(m_wvalid), 32'h0);
      step();
    end
    m_awready = 1'b1;
    #2;
    chk("t3_aw_fire", 32'(m_awvalid), 32'h1);
    step();
    #2;
    chk("t3_wvalid", 32'(m_wvalid), 32'h1);
    chk("t3_wdata_latched", m_wdata, 32'h33);
    chk("t3_awvalid_low", 32'(m_awvalid), 32'h0);
    step();
    #2;
    chk("t3_done", 32'(done), 32'h4);
    step();

    // Test 4: pointer wraps to requester 1; delayed B with EXOKAY.
    m_bvalid  = 1'b0;
    req_valid = 4'b0010;
    #2;
    chk("t4_req_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    #2;
    chk("t4_awaddr", m_awaddr, 32'h4);
    step();
    #2;
    chk("t4_wdata", m_wdata, 32'hFF);
    step();
    #2;
    chk("t4_bready_wait", 32'(m_bready), 32'h1);
    chk("t4_no_done_wait", 32'(done), 32'h0);
    step();
    m_bvalid = 1'b1;
    m_bresp  = 2'b01;
    #2;
    chk("t4_done", 32'(done), 32'h2);
    chk("t4_done_resp", 32'(done_resp), 32'h1);
    chk("t4_busy_at_done", 32'(busy), 32'h1);
    step();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    #2;
    chk("t4_busy_fall", 32'(busy), 32'h0);
    chk("t4_bready_fall", 32'(m_bready), 32'h0);
    chk("t4_done_after", 32'(done), 32'h0);

    // Test 5: reset during DATA aborts; pointer restarts at requester 0.
    req_data  = 32'h4433_2211;
    m_wready  = 1'b0;
    req_valid = 4'b0100;
    #2;
    chk("t5_req_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    #2;
    chk("t5_in_data", 32'(m_wvalid), 32'h1);
    resetn   = 1'b0;
    m_bvalid = 1'b1;
    m_wready = 1'b1;
    #1;
    chk("t5_rst_no_done", 32'(done), 32'h0);
    step();
    resetn   = 1'b1;
    m_bvalid = 1'b0;
    #2;
    chk("t5_awvalid", 32'(m_awvalid), 32'h0);
    chk("t5_wvalid", 32'(m_wvalid), 32'h0);
    chk("t5_bready", 32'(m_bready), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_awaddr", m_awaddr, 32'h0);
    chk("t5_wdata", m_wdata, 32'h0);
    step();
    req_valid = 4'b1111;
    #2;
    chk("t5_restart_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #2;
    chk("t5_restart_awaddr", m_awaddr, 32'h0);
    step();
    #2;
    chk("t5_restart_wdata", m_wdata, 32'h11);
    step();
    m_bvalid = 1'b1;
    #2;
    chk("t5_restart_done", 32'(done), 32'h1);
    step();
    m_bvalid = 1'b0;

    // Test 6: B never arrives.
    req_valid = 4'b0010;
    #2;
    chk("t6_req_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    step();
`ifdef SPI_SCHED_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      #2;
      chk("t6_wait_no_done", 32'(done), 32'h0);
      step();
    end
    #2;
    chk("t6_timeout_done", 32'(done), 32'h2);
    chk("t6_timeout_resp", 32'(done_resp), 32'h2);
    step();
    #2;
    chk("t6_idle_after", 32'(busy), 32'h0);
`else
    for (int i = 0; i < 100; i++) begin
      #2;
      chk("t6_wait_no_done", 32'(done), 32'h0);
      step();
    end
    #2;
    chk("t6_still_bready", 32'(m_bready), 32'h1);
    chk("t6_still_busy", 32'(busy), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
